wave_key_ctrl: RTL and testbench
================================

// Module: wave_key_ctrl
// PURPOSE
// - Sequences signal-generator configuration from debounced push-buttons.
// - Accepts one-cycle key_flag pulses from four key_filter instances and latches them as pending requests.
// - Serves pending requests one at a time by fixed priority, updating waveform select and DDS frequency word.
// - Delivers each update to the DDS core over a valid/ready handshake.
// PARAMETERS
// - FW_W        32           frequency-word width
// - FW_DEFAULT  32'd85899    reset/restore frequency word (1 kHz @ 50 MHz, 2^32 accumulator)
// - FW_STEP     32'd85899    increment/decrement per key press
// - FW_MIN      32'd85899    lowest legal frequency word
// - FW_MAX      32'd85899346 highest legal frequency word (1 MHz)
// PORTS
// - sys_clk    in   1     system clock; all logic is on the rising edge
// - sys_rst    in   1     asynchronous reset, active-high
// - key_flag   in   4     1-cycle debounced pulses: [0] wave next, [1] freq up, [2] freq down, [3] restore
// - cfg_ready  in   1     DDS core accepts the configuration this cycle
// - cfg_valid  out  1     configuration valid; held high until accepted
// - wave_sel   out  2     0 sine, 1 square, 2 triangle, 3 sawtooth
// - fword      out  FW_W  DDS frequency control word
// - grant_id   out  2     index of the key currently or last served
// - busy       out  1     high whenever state != IDLE
// BEHAVIOUR
// - Reset values: cfg_valid=0, wave_sel=0, fword=FW_DEFAULT, grant_id=0, busy=0, pending=0, state=IDLE.
// - pending[i] is set on the edge after key_flag[i]=1. Set wins over a same-cycle clear.
// - Repeat flags while pending[i]=1 merge into one request; there is no press counter.
// - FSM:
//   - IDLE: if pending!=0, grant the lowest set index (0 has highest priority), load grant_id, clear that bit, go to CALC.
//   - CALC: apply the operation, set cfg_valid=1, go to SEND.
//   - SEND: hold every output stable. On cfg_valid&&cfg_ready, cfg_valid=0 and go to IDLE.
// - Latency: key_flag in cycle N gives cfg_valid=1 from edge N+3 (no contention).
// - Back-to-back requests: IDLE is visited for at least 1 cycle between transactions.
// - Operations:
//   - wave next: wave_sel+1 mod 4 (3 wraps to 0).
//   - freq up: if fword > FW_MAX-FW_STEP, then FW_MAX; else fword+FW_STEP.
//   - freq down: if fword < FW_MIN+FW_STEP, then FW_MIN; else fword-FW_STEP.
//   - restore: wave_sel=0, fword=FW_DEFAULT.
// - Compares use FW_W+1-bit arithmetic, so no intermediate overflow.
// - An update is sent even when the value is unchanged (at a limit).
// - Flags arriving during CALC/SEND are latched and served after the current handshake.
// - Reset mid-transaction aborts it immediately: cfg_valid=0 and pending requests are discarded.
// CONFIGURATION
// - Macro WAVE_KEY_FREQ_WRAP_EN.
// - Defined: freq up past FW_MAX loads FW_MIN, and freq down past FW_MIN loads FW_MAX.
//   - "Past" uses the same thresholds as saturation.
//   - At exactly FW_MAX, up loads FW_MIN.
// - Undefined: saturating behaviour as in BEHAVIOUR.
// TESTING
// - Reset released, no keys -> cfg_valid=0, wave_sel=0, fword=85899, busy=0 for 100 cycles.
// - key_flag=4'b0001 pulse, cfg_ready tied 1 -> cfg_valid 1 cycle at N+3, wave_sel=1.
//   - 4 pulses in total -> wave_sel returns to 0.
// - key_flag=4'b0110 same cycle, cfg_ready=1 -> two handshakes: first grant_id=1 with fword=171798, then grant_id=2 with fword=85899.
// - fword at FW_MAX, press freq up -> fword stays 85899346, handshake still issued.
//   - With WAVE_KEY_FREQ_WRAP_EN -> fword=85899.
// - cfg_ready held 0 for 20 cycles -> cfg_valid and fields stable.
//   - key_flag[3] pulse during the wait -> served after ready rises; fword=85899.
// - sys_rst asserted in SEND -> cfg_valid=0 and pending cleared asynchronously.
//   - After release -> no spurious transaction.

Source files
------------

// File: rtl/wave_key_ctrl.sv
// Button-driven signal-generator configuration sequencer with a valid/ready DDS update port.
// Optional WAVE_KEY_FREQ_WRAP_EN: frequency steps wrap between the limits instead of saturating.
module wave_key_ctrl #(
  parameter int unsigned        FW_W       = 32,
  parameter logic [FW_W-1:0]    FW_DEFAULT = 32'd85899,
  parameter logic [FW_W-1:0]    FW_STEP    = 32'd85899,
  parameter logic [FW_W-1:0]    FW_MIN     = 32'd85899,
  parameter logic [FW_W-1:0]    FW_MAX     = 32'd85899346
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [3:0]      key_flag,
  input  logic            cfg_ready,
  output logic            cfg_valid,
  output logic [1:0]      wave_sel,
  output logic [FW_W-1:0] fword,
  output logic [1:0]      grant_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [FW_W:0] UP_LIM = {1'b0, FW_MAX} - {1'b0, FW_STEP};
  localparam logic [FW_W:0] DN_LIM = {1'b0, FW_MIN} + {1'b0, FW_STEP};

  state_t          state;
  state_t          state_n;
  logic [3:0]      pending;
  logic [3:0]      pend_clr;
  logic            cfg_valid_n;
  logic [1:0]      wave_n;
  logic [1:0]      grant_n;
  logic [FW_W-1:0] fw_n;
  logic [FW_W-1:0] fw_up;
  logic [FW_W-1:0] fw_dn;
  logic            up_over;
  logic            dn_under;

  // One extra bit keeps the limit compares free of wrap-around.
  assign up_over  = {1'b0, fword} > UP_LIM;
  assign dn_under = {1'b0, fword} < DN_LIM;

`ifdef WAVE_KEY_FREQ_WRAP_EN
  assign fw_up = up_over  ? FW_MIN : fword + FW_STEP;
  assign fw_dn = dn_under ? FW_MAX : fword - FW_STEP;
`else
  assign fw_up = up_over  ? FW_MAX : fword + FW_STEP;
  assign fw_dn = dn_under ? FW_MIN : fword - FW_STEP;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      pending   <= '0;
      cfg_valid <= 1'b0;
      wave_sel  <= 2'd0;
      fword     <= FW_DEFAULT;
      grant_id  <= 2'd0;
    end else begin
      state     <= state_n;
      pending   <= (pending & ~pend_clr) | key_flag;
      cfg_valid <= cfg_valid_n;
      wave_sel  <= wave_n;
      fword     <= fw_n;
      grant_id  <= grant_n;
    end
  end

  always_comb begin
    state_n     = state;
    pend_clr    = '0;
    cfg_valid_n = cfg_valid;
    wave_n      = wave_sel;
    fw_n        = fword;
    grant_n     = grant_id;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          state_n = CALC;
          priority case (1'b1)
            pending[0]: grant_n = 2'd0;
            pending[1]: grant_n = 2'd1;
            pending[2]: grant_n = 2'd2;
            default:    grant_n = 2'd3;
          endcase
          pend_clr[grant_n] = 1'b1;
        end
      end
      CALC: begin
        cfg_valid_n = 1'b1;
        state_n     = SEND;
        unique case (grant_id)
          2'd0: wave_n = wave_sel + 2'd1;
          2'd1: fw_n   = fw_up;
          2'd2: fw_n   = fw_dn;
          default: begin
            wave_n = 2'd0;
            fw_n   = FW_DEFAULT;
          end
        endcase
      end
      SEND: begin
        if (cfg_valid && cfg_ready) begin
          cfg_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wave_key_ctrl.sv
// Directed scoreboard bench for wave_key_ctrl.
// Expected updates are queued at key press and popped on each handshake.
module tb_wave_key_ctrl;

  localparam logic [31:0] FDEF  = 32'd85899;
  localparam logic [31:0] FSTEP = 32'd85899;
  localparam logic [31:0] FMIN  = 32'd85899;
  localparam logic [31:0] FMAX  = 32'd85899346;

  typedef struct packed {
    logic [1:0]  grant;
    logic [1:0]  wave;
    logic [31:0] fw;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  key_flag = 4'd0;
  logic        cfg_ready = 1'b0;
  logic        cfg_valid;
  logic [1:0]  wave_sel;
  logic [31:0] fword;
  logic [1:0]  grant_id;
  logic        busy;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_wave = 2'd0;
  logic [31:0] m_fw = FDEF;

  wave_key_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_flag  (key_flag),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .wave_sel  (wave_sel),
    .fword     (fword),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_up(input logic [31:0] f);
    if (longint'(f) > longint'(FMAX) - longint'(FSTEP))
`ifdef WAVE_KEY_FREQ_WRAP_EN
      return FMIN;
`else
      return FMAX;
`endif
    return f + FSTEP;
  endfunction

  function automatic logic [31:0] m_dn(input logic [31:0] f);
    if (longint'(f) < longint'(FMIN) + longint'(FSTEP))
`ifdef WAVE_KEY_FREQ_WRAP_EN
      return FMAX;
`else
      return FMIN;
`endif
    return f - FSTEP;
  endfunction

  task automatic model(input int k);
    case (k)
      0: m_wave = m_wave + 2'd1;
      1: m_fw = m_up(m_fw);
      2: m_fw = m_dn(m_fw);
      default: begin
        m_wave = 2'd0;
        m_fw   = FDEF;
      end
    endcase
    sb.push_back('{grant: 2'(k), wave: m_wave, fw: m_fw});
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge sys_clk);
    key_flag = k;
    for (int i = 0; i < 4; i++)
      if (k[i]) model(i);
    @(negedge sys_clk);
    key_flag = 4'd0;
  endtask

  task automatic serve(input string tag);
    exp_t e;
    int   n = 0;
    while (!(cfg_valid && cfg_ready) && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 60) begin
      chk({tag, "_timeout"}, 64'd1, 64'd0);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_grant"}, 64'(grant_id), 64'(e.grant));
      chk({tag, "_wave"}, 64'(wave_sel), 64'(e.wave));
      chk({tag, "_fword"}, 64'(fword), 64'(e.fw));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
    end
    @(negedge sys_clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cfg_valid && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 60) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_state", 64'({cfg_valid, wave_sel, fword, grant_id, busy}),
        64'({1'b0, 2'd0, FDEF, 2'd0, 1'b0}));
    sys_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      chk("idle_hold", 64'({cfg_valid, wave_sel, fword, busy}),
          64'({1'b0, 2'd0, FDEF, 1'b0}));
    end

    // First wave press: latency and single-cycle valid with ready tied high
    cfg_ready = 1'b1;
    @(negedge sys_clk);
    key_flag = 4'b0001;
    model(0);
    @(negedge sys_clk);
    key_flag = 4'd0;
    chk("lat_n1", 64'(cfg_valid), 64'd0);
    @(negedge sys_clk);
    chk("lat_n2", 64'(cfg_valid), 64'd0);
    @(negedge sys_clk);
    chk("lat_n3", 64'(cfg_valid), 64'd1);
    serve("wave1");
    chk("valid_one_cycle", 64'(cfg_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      press(4'b0001);
      serve("wave_wrap");
    end
    chk("wave_back_to_0", 64'(wave_sel), 64'd0);

    // Simultaneous up and down: priority order, IDLE between them
    press(4'b0110);
    serve("dual_up");
    chk("dual_gap_valid", 64'(cfg_valid), 64'd0);
    chk("dual_gap_busy", 64'(busy), 64'd0);
    serve("dual_dn");
    chk("dual_final_fw", 64'(fword), 64'(FDEF));

    // Down at the bottom limit still issues an update
    press(4'b0100);
    serve("dn_at_min");
    press(4'b1000);
    serve("restore1");

    // Climb to the top limit, then one more up
    for (int i = 0; i < 1100 && m_fw != FMAX; i++) begin
      press(4'b0010);
      serve("climb");
    end
    chk("reached_max", 64'(fword), 64'(FMAX));
    press(4'b0010);
    serve("up_at_max");
`ifdef WAVE_KEY_FREQ_WRAP_EN
    chk("up_at_max_val", 64'(fword), 64'(FMIN));
`else
    chk("up_at_max_val", 64'(fword), 64'(FMAX));
`endif

    // Back-pressure: outputs hold while ready is low; restore queued meanwhile
    cfg_ready = 1'b0;
    press(4'b0001);
    wait_valid("stall");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        key_flag = 4'b1000;
        model(3);
      end else begin
        key_flag = 4'd0;
      end
      chk("stall_hold",
          64'({cfg_valid, grant_id, wave_sel, fword}),
          64'({1'b1, sb[0].grant, sb[0].wave, sb[0].fw}));
      @(negedge sys_clk);
    end
    key_flag  = 4'd0;
    cfg_ready = 1'b1;
    serve("stall_wave");
    serve("stall_restore");
    chk("stall_restore_fw", 64'(fword), 64'(FDEF));

    // Reset during SEND with another request pending
    cfg_ready = 1'b0;
    press(4'b0001);
    wait_valid("rst_send");
    press(4'b0010);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_rst", 64'({cfg_valid, busy, wave_sel, fword}),
        64'({1'b0, 1'b0, 2'd0, FDEF}));
    sb.delete();
    m_wave = 2'd0;
    m_fw   = FDEF;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    cfg_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      chk("no_spurious", 64'({cfg_valid, busy}), 64'd0);
    end
    press(4'b0001);
    serve("post_rst");
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
